// File: rtl/biquad_cascade.sv
// biquad_cascade: time-multiplexed cascade of SECTIONS direct-form-I bi-quad
// IIR sections sharing one signed multiply-accumulate unit.
//
// Ports:
//   clk, nreset            clock (rising edge), synchronous active-low reset
//   x, in_valid, in_ready  sample input handshake (in_ready high only when idle)
//   clear                  synchronous flush of all delay lines, aborts a sample
//   coef_we/addr/wdata     coefficient bank write port, addr = section*5 + k
//                          (k: 0=b0 1=b1 2=b2 3=a1 4=a2)
//   yout, out_valid        filter output, one-cycle pulse when yout updates
//   sat_count              (only with BIQUAD_CASCADE_SATCNT_EN) sticky count of
//                          clipped section results
//
// Optional feature macro: BIQUAD_CASCADE_SATCNT_EN
module biquad_cascade #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned COEFWIDTH = 16,
  parameter int unsigned SECTIONS  = 4,
  parameter int unsigned ACCUM     = 4
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [DATAWIDTH-1:0] x,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 clear,
  input  logic                 coef_we,
  input  logic [7:0]           coef_addr,
  input  logic [COEFWIDTH-1:0] coef_wdata,
  output logic [DATAWIDTH-1:0] yout,
  output logic                 out_valid
`ifdef BIQUAD_CASCADE_SATCNT_EN
  ,
  output logic [15:0]          sat_count
`endif
);

  localparam int unsigned ACCW  = DATAWIDTH + COEFWIDTH + ACCUM;
  localparam int unsigned PW    = DATAWIDTH + COEFWIDTH;
  localparam int unsigned NCOEF = 5 * SECTIONS;
  localparam int unsigned CIW   = (NCOEF > 1) ? $clog2(NCOEF) : 1;
  localparam int unsigned SW    = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
  localparam int unsigned SHIFT = COEFWIDTH - 2;

  localparam logic signed [ACCW-1:0] RND = ACCW'(1) << (COEFWIDTH - 3);
  localparam logic signed [ACCW-1:0] SAT_MAX =
    {{(ACCW-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN =
    {{(ACCW-DATAWIDTH+1){1'b1}}, {(DATAWIDTH-1){1'b0}}};
  localparam logic signed [COEFWIDTH-1:0] B0_ONE = COEFWIDTH'(1) << (COEFWIDTH - 2);

  typedef enum logic [1:0] {IDLE, MAC, UPD, DONE} state_t;

  state_t state, state_next;

  logic signed [DATAWIDTH-1:0] x1 [SECTIONS];
  logic signed [DATAWIDTH-1:0] x2 [SECTIONS];
  logic signed [DATAWIDTH-1:0] y1 [SECTIONS];
  logic signed [DATAWIDTH-1:0] y2 [SECTIONS];
  logic signed [COEFWIDTH-1:0] coef [NCOEF];

  // Working register: the accepted sample, then each section's result.
  logic signed [DATAWIDTH-1:0] xin;
  logic [SW-1:0]               sec;
  logic [2:0]                  step;
  logic signed [ACCW-1:0]      acc;

  logic [CIW-1:0]              cidx_c;
  logic signed [DATAWIDTH-1:0] mul_a_c;
  logic signed [COEFWIDTH-1:0] mul_b_c;
  logic signed [PW-1:0]        prod_c;
  logic signed [ACCW-1:0]      prod_ext_c;
  logic signed [ACCW-1:0]      acc_rnd_c;
  logic signed [ACCW-1:0]      acc_shr_c;
  logic signed [DATAWIDTH-1:0] r_c;
  logic                        sat_c;

  // Shared MAC operand selection, rounding and saturation of the section result.
  always_comb begin
    cidx_c  = CIW'(int'(sec) * 5 + int'(step));
    mul_b_c = coef[cidx_c];
    case (step)
      3'd0:    mul_a_c = xin;
      3'd1:    mul_a_c = x1[sec];
      3'd2:    mul_a_c = x2[sec];
      3'd3:    mul_a_c = y1[sec];
      3'd4:    mul_a_c = y2[sec];
      default: mul_a_c = '0;
    endcase
    prod_c     = PW'(mul_a_c) * PW'(mul_b_c);
    prod_ext_c = ACCW'(prod_c);
    acc_rnd_c  = acc + RND;
    acc_shr_c  = acc_rnd_c >>> SHIFT;
    sat_c      = 1'b0;
    r_c        = DATAWIDTH'(acc_shr_c);
    if (acc_shr_c > SAT_MAX) begin
      r_c   = DATAWIDTH'(SAT_MAX);
      sat_c = 1'b1;
    end else if (acc_shr_c < SAT_MIN) begin
      r_c   = DATAWIDTH'(SAT_MIN);
      sat_c = 1'b1;
    end
  end

  // Next-state logic; clear overrides everything, including a new sample.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) state_next = MAC;
        MAC:  if (step == 3'd4) state_next = UPD;
        UPD:  state_next = (sec == SW'(SECTIONS - 1)) ? DONE : MAC;
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) state <= IDLE;
    else         state <= state_next;
  end

  // Datapath, coefficient bank and registered outputs.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < SECTIONS; i++) begin
        x1[SW'(i)] <= '0;
        x2[SW'(i)] <= '0;
        y1[SW'(i)] <= '0;
        y2[SW'(i)] <= '0;
      end
      for (int unsigned i = 0; i < NCOEF; i++)
        coef[CIW'(i)] <= (i % 5 == 0) ? B0_ONE : '0;
      xin       <= '0;
      sec       <= '0;
      step      <= '0;
      acc       <= '0;
      yout      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef BIQUAD_CASCADE_SATCNT_EN
      sat_count <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      in_ready  <= (state_next == IDLE);
      if (coef_we && (coef_addr < 8'(NCOEF)))
        coef[CIW'(coef_addr)] <= coef_wdata;
      if (clear) begin
        for (int unsigned i = 0; i < SECTIONS; i++) begin
          x1[SW'(i)] <= '0;
          x2[SW'(i)] <= '0;
          y1[SW'(i)] <= '0;
          y2[SW'(i)] <= '0;
        end
        step <= '0;
`ifdef BIQUAD_CASCADE_SATCNT_EN
        sat_count <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              xin  <= x;
              sec  <= '0;
              step <= '0;
            end
          end
          MAC: begin
            acc  <= (step == 3'd0) ? prod_ext_c : acc + prod_ext_c;
            step <= (step == 3'd4) ? 3'd0 : step + 3'd1;
          end
          UPD: begin
            x2[sec] <= x1[sec];
            x1[sec] <= xin;
            y2[sec] <= y1[sec];
            y1[sec] <= r_c;
            xin     <= r_c;
            if (sec != SW'(SECTIONS - 1)) sec <= sec + SW'(1);
`ifdef BIQUAD_CASCADE_SATCNT_EN
            if (sat_c && (sat_count != 16'hFFFF)) sat_count <= sat_count + 16'd1;
`endif
          end
          DONE: begin
            yout      <= xin;
            out_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_biquad_cascade.sv
// Testbench for biquad_cascade: table of filter vectors driven through a
// scoreboard queue, plus hand-written clear/reset/address corner sequences.
module tb_biquad_cascade;

  logic        clk = 1'b0;
  logic        nreset;
  logic [15:0] x;
  logic        in_valid;
  logic        in_ready;
  logic        clear;
  logic        coef_we;
  logic [7:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic [15:0] yout;
  logic        out_valid;
`ifdef BIQUAD_CASCADE_SATCNT_EN
  logic [15:0] sat_count;
`endif

  biquad_cascade dut (
    .clk        (clk),
    .nreset     (nreset),
    .x          (x),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .clear      (clear),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .yout       (yout),
    .out_valid  (out_valid)
`ifdef BIQUAD_CASCADE_SATCNT_EN
    ,
    .sat_count  (sat_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    bit          cfg;
    logic [15:0] b0;
    logic [15:0] a1;
    bit          clr;
    logic [15:0] xv;
    logic [15:0] yv;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every out_valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    logic [15:0] e;
    if (nreset === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected out_valid: yout=%0h with no sample pending", yout);
      end else begin
        e = exp_q.pop_front();
        check("yout", 32'(yout), 32'(e));
      end
    end
  end

  task automatic write_coef(input logic [7:0] a, input logic [15:0] d);
    coef_addr = a; coef_wdata = d; coef_we = 1'b1;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    check("in_ready before accept", 32'(in_ready), 32'd1);
  endtask

  // Accepts one sample, scrambles x and keeps in_valid high while busy (must be
  // ignored), then checks latency and that in_ready stayed low.
  task automatic send(input logic [15:0] xv, input logic [15:0] ev);
    int n;
    bit busy_ok;
    wait_ready();
    x = xv; in_valid = 1'b1;
    exp_q.push_back(ev);
    @(negedge clk);
    x = ~xv;
    n = 0;
    busy_ok = 1'b1;
    while (!out_valid && n < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("latency", 32'(n), 32'd25);
    check("in_ready low while busy", 32'(busy_ok), 32'd1);
  endtask

  task automatic accept_only(input logic [15:0] xv);
    wait_ready();
    x = xv; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    nreset = 1'b0; x = '0; in_valid = 1'b0; clear = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;

    //           cfg  b0        a1        clr  x         y
    vecs[0]  = '{1'b1, 16'h4000, 16'h0000, 1'b1, 16'h1234, 16'h1234};
    vecs[1]  = '{1'b1, 16'h2000, 16'h0000, 1'b1, 16'h4000, 16'h2000};
    vecs[2]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'hC000, 16'hE000};
    vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0001, 16'h0001};
    vecs[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'h0000};
    vecs[5]  = '{1'b1, 16'h4000, 16'h2000, 1'b1, 16'h4000, 16'h4000};
    vecs[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h2000};
    vecs[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h1000};
    vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0800};
    vecs[9]  = '{1'b1, 16'h7FFF, 16'h0000, 1'b1, 16'h7FFF, 16'h7FFF};
    vecs[10] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h8000, 16'h8000};

    repeat (3) @(negedge clk);
    nreset = 1'b1;
    check("reset yout", 32'(yout), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].cfg) begin
        write_coef(8'd0, vecs[i].b0);
        write_coef(8'd3, vecs[i].a1);
      end
      if (vecs[i].clr) do_clear();
      send(vecs[i].xv, vecs[i].yv);
    end
`ifdef BIQUAD_CASCADE_SATCNT_EN
    check("sat_count after clipping", 32'(sat_count), 32'd2);
`endif

    // Clear in the middle of a sample: no output, idle next cycle.
    write_coef(8'd0, 16'h4000);
    write_coef(8'd3, 16'h2000);
    do_clear();
    accept_only(16'h4000);
    repeat (9) @(negedge clk);
    do_clear();
    check("in_ready after clear", 32'(in_ready), 32'd1);
    check("out_valid after clear", 32'(out_valid), 32'd0);
`ifdef BIQUAD_CASCADE_SATCNT_EN
    check("sat_count cleared", 32'(sat_count), 32'd0);
`endif
    repeat (40) @(negedge clk);
    send(16'h4000, 16'h4000);
    send(16'h0000, 16'h2000);
    send(16'h0000, 16'h1000);
    send(16'h0000, 16'h0800);

    // Out-of-range addresses must not alias onto section 0's b0.
    write_coef(8'd3, 16'h0000);
    write_coef(8'd32, 16'h0000);
    write_coef(8'd20, 16'h0000);
    do_clear();
    send(16'h1234, 16'h1234);
    // Last section's b0 is reachable.
    write_coef(8'd15, 16'h2000);
    send(16'h4000, 16'h2000);
    write_coef(8'd15, 16'h4000);

    // Reset in the middle of a sample with non-default coefficients.
    write_coef(8'd0, 16'h2000);
    write_coef(8'd3, 16'h2000);
    accept_only(16'h1234);
    repeat (8) @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    check("mid reset yout", 32'(yout), 32'd0);
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset in_ready", 32'(in_ready), 32'd1);
    send(16'h1234, 16'h1234);

    repeat (40) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/biquad_cascade.md
Name: biquad_cascade

Overview:
- Time-multiplexed cascade of SECTIONS direct-form-I bi-quad IIR sections that shares one signed multiplier-accumulator across all sections.
- Coefficients sit in an internal register bank that is written through a simple write port.
- Uses a valid/ready input handshake, rounds and saturates between sections, and has a synchronous state clear.
- Next-generation filter core for higher-order filters in the same DSP datapath, replacing chains of fixed single sections.

Parameters:
- DATAWIDTH, 16, sample width; signed two's complement Q1.(DATAWIDTH-1).
- COEFWIDTH, 16, coefficient width; signed two's complement Q2.(COEFWIDTH-2), range [-2,2).
- SECTIONS, 4, number of cascaded bi-quad sections (1..16).
- ACCUM, 4, accumulator guard bits; accumulator width is DATAWIDTH+COEFWIDTH+ACCUM.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- nreset  in  1  synchronous active-low reset.
- x  in  DATAWIDTH  input sample.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample (high only in IDLE).
- clear  in  1  synchronous flush of all delay-line state.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  8  coefficient index = section*5 + k, with k: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
- coef_wdata  in  COEFWIDTH  coefficient value.
- yout  out  DATAWIDTH  filter output; held until the next result.
- out_valid  out  1  one-cycle pulse when yout updates.

Behaviour:
- Per-section equation: y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] + a1*y[n-1] + a2*y[n-2]. Feedback terms are added, so negation is folded into a1/a2.
- Each section keeps its own x1, x2, y1, y2 registers.
- States:
  - IDLE: in_ready=1. A cycle with in_valid & in_ready latches x into the working register, sets section=0, step=0 and goes to MAC.
  - MAC: one product per cycle, step 0..4. The acc is loaded at step 0 and accumulated at steps 1-4, with full-width sign-extended products. After step 4 go to UPD.
  - UPD: r = (acc + 2^(COEFWIDTH-3)) >>> (COEFWIDTH-2), i.e. round half up, then saturate to [-2^(DATAWIDTH-1), 2^(DATAWIDTH-1)-1].
    - Section state updates: x2<=x1, x1<=input, y2<=y1, y1<=r.
    - r becomes the next section's input.
    - If section==SECTIONS-1, go to DONE; otherwise section++ and go to MAC.
  - DONE: yout<=r, out_valid=1 for this cycle, then return to IDLE.
- Latency: acceptance edge to out_valid = 6*SECTIONS+1 cycles, i.e. 25 at default. Throughput is one sample per 6*SECTIONS+2 cycles.
- in_valid while in_ready=0 is ignored; there is no buffering, and the source must hold the sample.
- clear: in any state, zeroes every x1/x2/y1/y2, aborts any sample in flight (no out_valid) and forces IDLE the next cycle. Coefficients and yout are preserved. clear has priority over in_valid in the same cycle.
- Coefficient writes:
  - Applied at the clock edge in any state.
  - A write while busy affects subsequent MAC steps; software writes only when in_ready=1.
  - coef_addr >= 5*SECTIONS is ignored.
- Reset (nreset=0 at an edge, including mid-operation):
  - state=IDLE; yout=0; out_valid=0; in_ready=1 from the first cycle after reset.
  - All delay lines and acc = 0.
  - Coefficients: every b0 = 2^(COEFWIDTH-2) (1.0), all others 0, so the default cascade is passthrough.
- Saturation: only at UPD; the accumulator never wraps within ACCUM guard-bit range.

Optional Feature:
- Macro BIQUAD_CASCADE_SATCNT_EN.
- When defined: adds output port sat_count (16 bits). It increments each UPD cycle in which saturation clipped r, sticks at 0xFFFF, and is reset to 0 by nreset or clear.
- When undefined: the port and counter are absent, with no other behavioural change.

Test Plan:
- Reset passthrough: after reset, x=0x1234 accepted -> out_valid 25 cycles later, yout=0x1234, in_ready low throughout.
- Gain: section0 b0=0x2000 (0.5), x=0x4000 -> yout=0x2000.
- Recursion: section0 b0=0x4000, a1=0x2000, other sections passthrough; inputs 0x4000,0,0,0 -> yout sequence 0x4000, 0x2000, 0x1000, 0x0800.
- Saturation: section0 b0=0x7FFF; x=0x7FFF -> yout=0x7FFF; x=0x8000 -> yout=0x8000 (sat_count=2 if enabled).
- Clear mid-sample: assert clear 10 cycles after acceptance -> no out_valid, in_ready=1 next cycle. Re-running the recursion test then gives the identical sequence from zero state.
- Reset mid-sample with non-default coefficients: nreset low for 1 cycle during MAC -> yout=0, out_valid=0. The next x=0x1234 returns 0x1234 (passthrough restored).
